// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: store-and-forward receive buffer that forwards only complete good frames
module rx_frame_buffer #(
    parameter int ADDR_W    = 11,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_W     = 16
) (
    input  logic             rx_mac_clk,
    input  logic             rstn,
    input  logic             rx_mac_valid,
    input  logic [7:0]       rx_mac_data,
    input  logic             rx_mac_last,
    input  logic             rx_mac_error,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LEN_W = $clog2(MAX_FRAME + 2);
    typedef enum logic {WR_RECV, WR_DROP} wr_state_t;
    wr_state_t state, state_nx;
    logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr, wr_ptr_nx, commit_ptr_nx, used;
    logic [LEN_W-1:0] len, len_nx, len_inc;
    logic [8:0] mem [DEPTH];
    logic [8:0] ram_q, skid;
    logic full, over, we, commit, drop;
    logic rd_en, rd_pend, skid_valid, pop;
    logic [1:0] slots;
    assign used    = wr_ptr - rd_ptr;
    assign full    = used == (ADDR_W+1)'(DEPTH);
    assign len_inc = len + 1'b1;
    assign over    = len_inc > LEN_W'(MAX_FRAME);
    // write side: accept, rewind or commit each incoming byte of the current frame
    always_comb begin
        state_nx      = state;
        wr_ptr_nx     = wr_ptr;
        commit_ptr_nx = commit_ptr;
        len_nx        = len;
        we            = 1'b0;
        commit        = 1'b0;
        drop          = 1'b0;
        if (rx_mac_valid) begin
            if (state == WR_DROP) begin
                if (rx_mac_last) begin
                    drop     = 1'b1;
                    len_nx   = '0;
                    state_nx = WR_RECV;
                end
            end else if (full || over) begin
                wr_ptr_nx = commit_ptr;
                len_nx    = rx_mac_last ? '0 : len_inc;
                drop      = rx_mac_last;
                state_nx  = rx_mac_last ? WR_RECV : WR_DROP;
            end else if (rx_mac_last) begin
                len_nx = '0;
                if (!rx_mac_error && len_inc >= LEN_W'(MIN_FRAME)) begin
                    we            = 1'b1;
                    commit        = 1'b1;
                    wr_ptr_nx     = wr_ptr + 1'b1;
                    commit_ptr_nx = wr_ptr + 1'b1;
                end else begin
                    wr_ptr_nx = commit_ptr;
                    drop      = 1'b1;
                end
            end else begin
                we        = 1'b1;
                wr_ptr_nx = wr_ptr + 1'b1;
                len_nx    = len_inc;
            end
        end
    end
    // write-side state, pointers and saturating statistics
    always_ff @(posedge rx_mac_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= WR_RECV;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            len        <= '0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_nx;
            wr_ptr     <= wr_ptr_nx;
            commit_ptr <= commit_ptr_nx;
            len        <= len_nx;
            frame_cnt  <= frame_cnt + CNT_W'(commit && (frame_cnt != '1));
            drop_cnt   <= drop_cnt + CNT_W'(drop && (drop_cnt != '1));
        end
    end
    // frame storage: {last, data} per byte with one-cycle read latency
    always_ff @(posedge rx_mac_clk) begin
        if (we) mem[wr_ptr[ADDR_W-1:0]] <= {rx_mac_last, rx_mac_data};
        if (rd_en) ram_q <= mem[rd_ptr[ADDR_W-1:0]];
    end
    // only committed bytes are fetched; a fetch is issued only if a slot (output or skid) will be free
    assign pop   = out_valid && out_ready;
    assign slots = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);
    assign rd_en = (commit_ptr != rd_ptr) && (slots < 2'd2);
    // output register fed from the skid slot first, then from the RAM read in flight
    always_ff @(posedge rx_mac_clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr     <= '0;
            rd_pend    <= 1'b0;
            skid_valid <= 1'b0;
            skid       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (!out_valid || out_ready) begin
                out_valid <= skid_valid || rd_pend;
                if (skid_valid) {out_last, out_data} <= skid;
                else if (rd_pend) {out_last, out_data} <= ram_q;
                skid_valid <= skid_valid && rd_pend;
                if (rd_pend) skid <= ram_q;
            end else if (rd_pend) begin
                skid_valid <= 1'b1;
                skid       <= ram_q;
            end
        end
    end
endmodule

// File: tb/tb_rx_frame_buffer.sv
// tb_rx_frame_buffer: directed and randomized frames checked against a queue-based frame model
`timescale 1ns/1ps
module tb_rx_frame_buffer;
    localparam int DEPTH = 2048, MIN_FRAME = 64, MAX_FRAME = 1518, CNT_MAX = 65535;
    logic clk = 1'b0, rstn = 1'b0;
    logic rx_mac_valid = 1'b0, rx_mac_last = 1'b0, rx_mac_error = 1'b0;
    logic [7:0] rx_mac_data = 8'h00;
    logic out_valid, out_last;
    logic out_ready = 1'b0;
    logic [7:0] out_data;
    logic [15:0] frame_cnt, drop_cnt;
    int passed = 0, total = 0;
    int rdy_mode = 0, tog = 0;
    logic [8:0] exp_q[$];
    logic [8:0] pend[$];
    logic [8:0] e_byte, prev_out = '0;
    int m_len = 0, m_frames = 0, m_drops = 0, xfers = 0, lasts = 0, idle = 0;
    bit m_ovf = 0, prev_stall = 0;

    always #5 clk = ~clk;

    rx_frame_buffer dut (
        .rx_mac_clk(clk), .rstn(rstn),
        .rx_mac_valid(rx_mac_valid), .rx_mac_data(rx_mac_data),
        .rx_mac_last(rx_mac_last), .rx_mac_error(rx_mac_error),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    function automatic void check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // model and output checker; inputs seen here are sampled by the DUT at the next rising edge
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            pend.delete();
            m_len = 0; m_ovf = 0; m_frames = 0; m_drops = 0; idle = 0; prev_stall = 0;
        end else begin
            check("frame_cnt", frame_cnt, m_frames);
            check("drop_cnt", drop_cnt, m_drops);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", {out_last, out_data}, prev_out);
            end
            if (exp_q.size() != 0) begin
                idle = out_valid ? 0 : idle + 1;
                check("valid_gap", idle > 3, 0);
            end else idle = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 0);
                else begin
                    e_byte = exp_q.pop_front();
                    check("out_byte", {out_last, out_data}, e_byte);
                    xfers++;
                    if (out_last) lasts++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out = {out_last, out_data};
            if (rx_mac_valid) begin
                m_len++;
                if (!m_ovf && m_len <= MAX_FRAME) begin
                    if (exp_q.size() + pend.size() >= DEPTH) m_ovf = 1;
                    else pend.push_back({rx_mac_last, rx_mac_data});
                end
                if (rx_mac_last) begin
                    if (!rx_mac_error && !m_ovf && m_len >= MIN_FRAME && m_len <= MAX_FRAME) begin
                        foreach (pend[i]) exp_q.push_back(pend[i]);
                        if (m_frames < CNT_MAX) m_frames++;
                    end else if (m_drops < CNT_MAX) m_drops++;
                    pend.delete();
                    m_len = 0;
                    m_ovf = 0;
                end
            end
        end
    end

    // downstream ready pattern: always, never, 1-0-0 repeating, or random 3/4
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = 1'b0;
            else if (rdy_mode == 2) begin
                out_ready = (tog == 0);
                tog = (tog + 1) % 3;
            end else out_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input logic e, input int gap);
        while ($urandom_range(99) < gap) tick();
        rx_mac_valid = 1'b1; rx_mac_data = d; rx_mac_last = l; rx_mac_error = e;
        tick();
        rx_mac_valid = 1'b0; rx_mac_last = 1'b0; rx_mac_error = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit err, input int gap, input logic [7:0] base);
        for (int i = 0; i < n; i++) send_byte(8'(base + i), i == n - 1, err && (i == n - 1), gap);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, out_valid, 0);
    endtask

    initial begin
        int x0, l0, n, sel, cyc;
        int b[4] = '{63, 64, 1518, 1519};
        repeat (2) tick();
        do_reset();
        // single minimum-length good frame, full-rate output
        rdy_mode = 0;
        x0 = xfers; l0 = lasts;
        send_frame(64, 0, 0, 8'h00);
        cyc = 0;
        while (xfers - x0 < 64 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("good_burst_cycles", cyc <= 67, 1);
        wait_drain("good", 200);
        check("good_bytes", xfers - x0, 64);
        check("good_lasts", lasts - l0, 1);
        check("good_frame_cnt", frame_cnt, 1);
        check("good_drop_cnt", drop_cnt, 0);
        check("good_model_frames", m_frames, 1);
        // errored frame then good frame
        do_reset();
        x0 = xfers;
        send_frame(100, 1, 0, 8'h80);
        repeat (5) tick();
        check("err_no_valid", out_valid, 0);
        check("err_drop_cnt", drop_cnt, 1);
        send_frame(64, 0, 0, 8'h40);
        wait_drain("err", 300);
        check("err_bytes", xfers - x0, 64);
        check("err_frame_cnt", frame_cnt, 1);
        // runt, oversize by one, maximum length
        do_reset();
        x0 = xfers;
        send_frame(63, 0, 0, 8'h10);
        send_frame(1519, 0, 0, 8'h20);
        send_frame(1518, 0, 0, 8'h30);
        wait_drain("size", 3000);
        check("size_drop_cnt", drop_cnt, 2);
        check("size_frame_cnt", frame_cnt, 1);
        check("size_bytes", xfers - x0, 1518);
        check("size_model_drops", m_drops, 2);
        // overflow with downstream stalled
        do_reset();
        rdy_mode = 1;
        tick();
        x0 = xfers;
        send_frame(1500, 0, 0, 8'h00);
        send_frame(1000, 0, 0, 8'h07);
        repeat (5) tick();
        check("ovf_drop_cnt", drop_cnt, 1);
        check("ovf_frame_cnt", frame_cnt, 1);
        check("ovf_stalled_valid", out_valid, 1);
        check("ovf_stalled_bytes", xfers - x0, 0);
        rdy_mode = 0;
        wait_drain("ovf", 3000);
        check("ovf_bytes", xfers - x0, 1500);
        x0 = xfers;
        send_frame(64, 0, 0, 8'hC0);
        wait_drain("ovf_next", 300);
        check("ovf_next_bytes", xfers - x0, 64);
        check("ovf_next_frame_cnt", frame_cnt, 2);
        // backpressure 1,0,0 with input gaps
        do_reset();
        rdy_mode = 2;
        x0 = xfers;
        send_frame(200, 0, 40, 8'h11);
        wait_drain("bp", 2000);
        check("bp_bytes", xfers - x0, 200);
        check("bp_frame_cnt", frame_cnt, 1);
        // reset in the middle of a frame; the remainder is a runt
        rdy_mode = 0;
        do_reset();
        for (int i = 0; i < 30; i++) send_byte(8'(i), 1'b0, 1'b0, 0);
        do_reset();
        for (int i = 30; i < 64; i++) send_byte(8'(i), i == 63, 1'b0, 0);
        repeat (5) tick();
        check("rst_mid_drop_cnt", drop_cnt, 1);
        check("rst_mid_frame_cnt", frame_cnt, 0);
        check("rst_mid_no_valid", out_valid, 0);
        x0 = xfers;
        send_frame(64, 0, 0, 8'h55);
        wait_drain("rst_mid", 300);
        check("rst_mid_bytes", xfers - x0, 64);
        check("rst_mid_next_frame_cnt", frame_cnt, 1);
        // randomized mix of lengths, errors, gaps and ready
        do_reset();
        rdy_mode = 3;
        for (int f = 0; f < 40; f++) begin
            sel = $urandom_range(9);
            if (sel < 4) n = $urandom_range(80, 1);
            else if (sel < 8) n = $urandom_range(400, 60);
            else if (sel == 8) n = $urandom_range(1530, 1500);
            else n = b[$urandom_range(3)];
            send_frame(n, $urandom_range(7) == 0, 30, 8'($urandom));
        end
        wait_drain("random", 5000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
